// File: rtl/pulse_frame_pkg.sv
// Shared constants and state encoding for the pulse-ID frame builder.
package pulse_frame_pkg;

  localparam logic [7:0]  SyncByteDefault = 8'hA5;
  localparam int unsigned FieldBytes      = 3;
  localparam int unsigned BaseFrameLen    = 13;
  localparam logic [7:0]  CrcPoly         = 8'h07;
  // Sync + four fields + up to three timestamp bytes + optional CRC.
  localparam int unsigned MaxFrameLen     = BaseFrameLen + 3 + 1;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StRelease,
    StSend,
    StDone
  } state_e;

  function automatic int unsigned frame_len(int unsigned ts_bytes, bit with_crc);
    return BaseFrameLen + ts_bytes + (with_crc ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/pulse_id_framer_if.sv
// Byte-stream valid/ready link from the framer to a UART/SPI byte sink.
interface pulse_id_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/crc8_update.sv
// One-byte CRC-8 step, MSB first, no reflection.
module crc8_update
  import pulse_frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CrcPoly) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/pulse_id_framer.sv
// Captures an identifier result, releases the identifier and streams it as a byte frame.
// Optional trailing CRC-8 byte when PULSE_FRAME_CRC_EN is defined.
module pulse_id_framer
  import pulse_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault,
  parameter int unsigned TS_BYTES  = 3
) (
  input  logic                      clk_96MHz,
  input  logic                      reset,
  input  logic [16:0]               pulse_id_0,
  input  logic [16:0]               pulse_id_1,
  input  logic [16:0]               pulse_id_2,
  input  logic [16:0]               polynomial,
  input  logic                      id_ready,
  input  logic [23:0]               sys_ts,
  output logic                      id_reset,
  output logic                      busy,
  pulse_id_framer_if.master         tx
);

`ifdef PULSE_FRAME_CRC_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif
  localparam int unsigned FrameLen = frame_len(TS_BYTES, CrcEn);
  localparam logic [4:0]  LastIdx  = 5'(FrameLen - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        capture;
  logic [16:0] poly_q, id0_q, id1_q, id2_q;
  logic [23:0] ts_q;
  logic [23:0] field_words [4];
  logic [7:0]  frame_bytes [MaxFrameLen];
  logic        transfer;

  assign transfer = (state_q == StSend) && tx.tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (id_ready) begin
          capture = 1'b1;
          state_d = StCapture;
        end
      end
      StCapture: state_d = StRelease;
      StRelease: begin
        if (!id_ready) state_d = StSend;
      end
      StSend: begin
        if (tx.tx_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      poly_q  <= '0;
      id0_q   <= '0;
      id1_q   <= '0;
      id2_q   <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        poly_q <= polynomial;
        id0_q  <= pulse_id_0;
        id1_q  <= pulse_id_1;
        id2_q  <= pulse_id_2;
        ts_q   <= sys_ts;
      end
    end
  end

`ifdef PULSE_FRAME_CRC_EN
  logic [7:0] crc_q, crc_next;

  crc8_update u_crc (
    .crc_in  (crc_q),
    .data    (frame_bytes[idx_q]),
    .crc_out (crc_next)
  );

  // Sync byte and the CRC byte itself are excluded from the checksum.
  always_ff @(posedge clk_96MHz) begin
    if (reset || state_q == StCapture) begin
      crc_q <= '0;
    end else if (transfer && idx_q != 5'd0 && idx_q != LastIdx) begin
      crc_q <= crc_next;
    end
  end
`endif

  always_comb begin
    field_words[0] = {7'b0, poly_q};
    field_words[1] = {7'b0, id0_q};
    field_words[2] = {7'b0, id1_q};
    field_words[3] = {7'b0, id2_q};
    for (int i = 0; i < int'(MaxFrameLen); i++) frame_bytes[i] = 8'h00;
    frame_bytes[0] = SYNC_BYTE;
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < int'(FieldBytes); b++) begin
        frame_bytes[1 + f * int'(FieldBytes) + b] = field_words[f][8*b +: 8];
      end
    end
    for (int t = 0; t < int'(TS_BYTES); t++) begin
      frame_bytes[int'(BaseFrameLen) + t] = ts_q[8*t +: 8];
    end
`ifdef PULSE_FRAME_CRC_EN
    frame_bytes[FrameLen - 1] = crc_q;
`endif
  end

  // Outputs are gated by reset so they drop in the same cycle reset rises.
  always_comb begin
    tx.tx_valid = !reset && (state_q == StSend);
    tx.tx_data  = tx.tx_valid ? frame_bytes[idx_q] : 8'h00;
    id_reset    = !reset && ((state_q == StCapture) || (state_q == StRelease && id_ready));
    busy        = !reset && (state_q != StIdle);
  end

endmodule

// File: tb/tb_pulse_id_framer.sv
// Directed bench for pulse_id_framer; covers handshake, stalls, reset abort and requeue.
module tb_pulse_id_framer;

`ifdef PULSE_FRAME_CRC_EN
  localparam int FrameLen = 17;
`else
  localparam int FrameLen = 16;
`endif

  logic        clk_96MHz = 1'b0;
  logic        reset;
  logic [16:0] pulse_id_0, pulse_id_1, pulse_id_2, polynomial;
  logic        id_ready;
  logic [23:0] sys_ts;
  logic        id_reset, busy;

  pulse_id_framer_if tx_if ();

  pulse_id_framer dut (
    .clk_96MHz  (clk_96MHz),
    .reset      (reset),
    .pulse_id_0 (pulse_id_0),
    .pulse_id_1 (pulse_id_1),
    .pulse_id_2 (pulse_id_2),
    .polynomial (polynomial),
    .id_ready   (id_ready),
    .sys_ts     (sys_ts),
    .id_reset   (id_reset),
    .busy       (busy),
    .tx         (tx_if)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] crc8_ref(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic append_crc();
`ifdef PULSE_FRAME_CRC_EN
    logic [7:0] c;
    c = 8'h00;
    for (int k = 1; k < exp_q.size(); k++) c = crc8_ref(c, exp_q[k]);
    exp_q.push_back(c);
`endif
  endtask

  task automatic set_fields(input logic [16:0] p, input logic [16:0] i0, input logic [16:0] i1,
                            input logic [16:0] i2, input logic [23:0] ts);
    polynomial = p;
    pulse_id_0 = i0;
    pulse_id_1 = i1;
    pulse_id_2 = i2;
    sys_ts     = ts;
  endtask

  task automatic fill_expected(input logic [16:0] p, input logic [16:0] i0, input logic [16:0] i1,
                               input logic [16:0] i2, input logic [23:0] ts);
    logic [23:0] w [4];
    w[0] = {7'b0, p};
    w[1] = {7'b0, i0};
    w[2] = {7'b0, i1};
    w[3] = {7'b0, i2};
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back(w[f][7:0]);
      exp_q.push_back(w[f][15:8]);
      exp_q.push_back(w[f][23:16]);
    end
    exp_q.push_back(ts[7:0]);
    exp_q.push_back(ts[15:8]);
    exp_q.push_back(ts[23:16]);
    append_crc();
  endtask

  // Raise id_ready, keep it high for `hold` cycles of id_reset, then drop it.
  task automatic start_capture(input int hold);
    bit seen;
    seen = 1'b0;
    id_ready = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_96MHz);
      if (id_reset === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL id_reset_rise: got 0 expected 1 within 10 cycles");
    end
    for (int h = 0; h < hold; h++) begin
      n_checks++;
      if (id_reset !== 1'b1 || tx_if.tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL id_reset_hold[%0d]: got id_reset=%b tx_valid=%b expected 1/0", h,
                 id_reset, tx_if.tx_valid);
      end
      @(negedge clk_96MHz);
    end
    id_ready = 1'b0;
    #1;
    n_checks++;
    if (id_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL id_reset_drop: got %b expected 0", id_reset);
    end
  endtask

  // Records bytes transferred; pattern 1 gives tx_ready one cycle high, two low.
  task automatic collect(input int pattern, input int nbytes, input int raise_at,
                         output bit timed_out, output int stall_err);
    logic [7:0] prev;
    bit         prev_stall;
    bit         done;
    prev       = 8'h00;
    prev_stall = 1'b0;
    done       = 1'b0;
    stall_err  = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk_96MHz);
      if (cyc == raise_at) id_ready = 1'b1;
      if (prev_stall && tx_if.tx_data !== prev) stall_err++;
      tx_if.tx_ready = (pattern == 0) ? 1'b1 : (cyc % 3 == 0);
      if (tx_if.tx_valid && tx_if.tx_ready) got_q.push_back(tx_if.tx_data);
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev       = tx_if.tx_data;
      if (got_q.size() == nbytes) done = 1'b1;
    end
    timed_out = !done;
    tx_if.tx_ready = 1'b1;
  endtask

  task automatic check_tail(input string name);
    @(negedge clk_96MHz);
    n_checks++;
    if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: got valid=%b data=%h busy=%b expected 0/00/1", name,
               tx_if.tx_valid, tx_if.tx_data, busy);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    id_ready = 1'b1;
    repeat (2) @(negedge clk_96MHz);
    n_checks++;
    if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00 || id_reset !== 1'b0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b data=%h id_reset=%b busy=%b expected 0/00/0/0",
               tx_if.tx_valid, tx_if.tx_data, id_reset, busy);
    end
    id_ready = 1'b0;
    @(negedge clk_96MHz);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] tab [16] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h20,
                             8'h00, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h56, 8'h34, 8'h12};
    bit to;
    int se;
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(tab[k]);
    append_crc();
    set_fields(17'h1, 17'h00010, 17'h00020, 17'h1FFFF, 24'h123456);
    start_capture(1);
    collect(0, FrameLen, -1, to, se);
    n_checks++;
    if (to || got_q.size() != FrameLen) begin
      n_fail++;
      $display("FAIL basic_len: got %0d expected %0d", got_q.size(), FrameLen);
    end
    for (int k = 0; k < FrameLen && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL basic_byte[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    check_tail("basic");
    @(negedge clk_96MHz);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_stall();
    bit to;
    int se;
    fill_expected(17'h1, 17'h00010, 17'h00020, 17'h1FFFF, 24'h123456);
    start_capture(1);
    collect(1, FrameLen, -1, to, se);
    n_checks++;
    if (to || se != 0) begin
      n_fail++;
      $display("FAIL stall_hold: got timeout=%b unstable=%0d expected 0/0", to, se);
    end
    for (int k = 0; k < FrameLen && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stall_byte[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    check_tail("stall");
    @(negedge clk_96MHz);
  endtask

  task automatic test_hold();
    bit to;
    int se;
    set_fields(17'h0ABCD, 17'h00100, 17'h10001, 17'h07777, 24'h00FF00);
    fill_expected(17'h0ABCD, 17'h00100, 17'h10001, 17'h07777, 24'h00FF00);
    start_capture(5);
    collect(0, FrameLen, -1, to, se);
    n_checks++;
    if (to || got_q.size() != FrameLen || got_q[0] !== 8'hA5 || got_q[1] !== 8'hCD ||
        got_q[FrameLen-1] !== exp_q[FrameLen-1]) begin
      n_fail++;
      $display("FAIL hold_frame: got size=%0d first=%h expected %0d/a5", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'h00, FrameLen);
    end
    check_tail("hold");
    @(negedge clk_96MHz);
  endtask

  task automatic test_reset_abort();
    bit to;
    int se;
    set_fields(17'h1, 17'h00010, 17'h00020, 17'h1FFFF, 24'h123456);
    start_capture(1);
    collect(0, 6, -1, to, se);
    reset = 1'b1;
    #1;
    n_checks++;
    if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_gate: got valid=%b data=%h expected 0/00", tx_if.tx_valid,
               tx_if.tx_data);
    end
    @(negedge clk_96MHz);
    n_checks++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got valid=%b busy=%b expected 0/0", tx_if.tx_valid, busy);
    end
    reset = 1'b0;
    set_fields(17'h1ABCD, 17'h00001, 17'h0F0F0, 17'h10000, 24'hABCDEF);
    fill_expected(17'h1ABCD, 17'h00001, 17'h0F0F0, 17'h10000, 24'hABCDEF);
    start_capture(1);
    collect(0, FrameLen, -1, to, se);
    n_checks++;
    if (to || got_q.size() != FrameLen) begin
      n_fail++;
      $display("FAIL abort_len: got %0d expected %0d", got_q.size(), FrameLen);
    end
    for (int k = 0; k < FrameLen && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL abort_byte[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    check_tail("abort");
    @(negedge clk_96MHz);
  endtask

  task automatic test_zero();
    bit to;
    int se;
    set_fields('0, '0, '0, '0, '0);
    fill_expected('0, '0, '0, '0, '0);
    start_capture(1);
    collect(0, FrameLen, -1, to, se);
    n_checks++;
    if (to || got_q.size() != FrameLen) begin
      n_fail++;
      $display("FAIL zero_len: got %0d expected %0d", got_q.size(), FrameLen);
    end
    for (int k = 0; k < FrameLen && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL zero_byte[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    check_tail("zero");
    @(negedge clk_96MHz);
  endtask

  task automatic test_requeue();
    bit to;
    int se;
    set_fields(17'h1, 17'h00010, 17'h00020, 17'h1FFFF, 24'h123456);
    fill_expected(17'h1, 17'h00010, 17'h00020, 17'h1FFFF, 24'h123456);
    start_capture(1);
    // New result appears mid-frame; shadows must keep the first capture.
    set_fields(17'h1ABCD, 17'h00001, 17'h0F0F0, 17'h10000, 24'hABCDEF);
    collect(0, FrameLen, 2, to, se);
    n_checks++;
    if (to || got_q.size() != FrameLen) begin
      n_fail++;
      $display("FAIL requeue_len1: got %0d expected %0d", got_q.size(), FrameLen);
    end
    for (int k = 0; k < FrameLen && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL requeue_first[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    check_tail("requeue");
    n_checks++;
    if (id_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL requeue_early: got id_reset=%b expected 0 in DONE", id_reset);
    end
    fill_expected(17'h1ABCD, 17'h00001, 17'h0F0F0, 17'h10000, 24'hABCDEF);
    start_capture(1);
    collect(0, FrameLen, -1, to, se);
    n_checks++;
    if (to || got_q.size() != FrameLen) begin
      n_fail++;
      $display("FAIL requeue_len2: got %0d expected %0d", got_q.size(), FrameLen);
    end
    for (int k = 0; k < FrameLen && k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL requeue_second[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
      end
    end
    check_tail("requeue2");
    @(negedge clk_96MHz);
  endtask

  initial begin
    reset          = 1'b1;
    id_ready       = 1'b0;
    tx_if.tx_ready = 1'b1;
    set_fields('0, '0, '0, '0, '0);
    test_reset();
    test_basic();
    test_stall();
    test_hold();
    test_reset_abort();
    test_zero();
    test_requeue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
